aibio_rx_ofscal_ctrl: RTL and testbench



---
 rtl/aibio_rx_ofscal_pkg.sv | 26 ++
 rtl/aibio_rx_ofscal_sync.sv | 20 ++
 rtl/aibio_rx_ofscal_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_aibio_rx_ofscal_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aibio_rx_ofscal_pkg.sv
// Shared types and constants for the RX sampler offset-calibration controller.
package aibio_rx_ofscal_pkg;

  localparam int unsigned CODE_W = 8;
  localparam logic [CODE_W-1:0] CODE_MID = 8'h80;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DECIDE,
    ST_DONE
  } state_e;

  typedef enum logic {
    SEL_EVEN,
    SEL_ODD
  } sel_e;

  // A trim code pinned at either rail means the search ran out of range.
  function automatic logic code_sat(input logic [CODE_W-1:0] code);
    return (code == '0) || (code == '1);
  endfunction

endpackage

// File: rtl/aibio_rx_ofscal_sync.sv
// Multi-flop synchroniser for one asynchronous sampler output, reset to 0.
module aibio_rx_ofscal_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge clk) begin
    if (!rst_n) r_sync <= '0;
    else        r_sync <= STAGES'({r_sync, i_d});
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/aibio_rx_ofscal_ctrl.sv
// Successive-approximation offset calibration of the even then odd RX sampler.
// Optional RX_OFSCAL_OVRD_EN adds a direct trim-code override path.
module aibio_rx_ofscal_ctrl
  import aibio_rx_ofscal_pkg::*;
#(
  parameter int unsigned SETTLE_CYC  = 16,
  parameter int unsigned NAVG        = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cal_start,
  input  logic              rx_en,
  input  logic              rx_out_even,
  input  logic              rx_out_odd,
`ifdef RX_OFSCAL_OVRD_EN
  input  logic              ovrd_en,
  input  logic [CODE_W-1:0] ovrd_code_even,
  input  logic [CODE_W-1:0] ovrd_code_odd,
`endif
  output logic              rx_calen,
  output logic [CODE_W-1:0] rx_ofscal_even,
  output logic [CODE_W-1:0] rx_ofscal_odd,
  output logic              cal_busy,
  output logic              cal_done,
  output logic              cal_err
);

  localparam int unsigned CNT_MAX = (SETTLE_CYC > NAVG) ? SETTLE_CYC : NAVG;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned ONES_W  = $clog2(NAVG + 1);
  localparam int unsigned IDX_W   = $clog2(CODE_W);

  if (SETTLE_CYC < SYNC_STAGES + 1) begin : g_chk_settle
    $error("SETTLE_CYC must be at least SYNC_STAGES+1");
  end
  if (NAVG < 1 || NAVG > 64) begin : g_chk_navg
    $error("NAVG must be in 1..64");
  end
  if (SYNC_STAGES < 1) begin : g_chk_sync
    $error("SYNC_STAGES must be at least 1");
  end

  state_e              r_state, w_state;
  sel_e                r_sel, w_sel;
  logic [IDX_W-1:0]    r_idx, w_idx;
  logic [CNT_W-1:0]    r_cnt, w_cnt;
  logic [ONES_W-1:0]   r_ones, w_ones;
  logic [CODE_W-1:0]   r_code_even, w_code_even;
  logic [CODE_W-1:0]   r_code_odd, w_code_odd;
  logic                r_calen, w_calen;
  logic                r_busy, w_busy;
  logic                r_done, w_done;
  logic                r_err, w_err;

  logic                w_sync_even, w_sync_odd;
  logic                w_sample;
  logic                w_dec;
  logic [CODE_W-1:0]   w_active;
  logic [CODE_W-1:0]   w_trial;

  aibio_rx_ofscal_sync #(.STAGES(SYNC_STAGES)) u_sync_even (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (rx_out_even),
    .o_q   (w_sync_even)
  );

  aibio_rx_ofscal_sync #(.STAGES(SYNC_STAGES)) u_sync_odd (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (rx_out_odd),
    .o_q   (w_sync_odd)
  );

  assign w_sample = (r_sel == SEL_ODD) ? w_sync_odd : w_sync_even;
  assign w_active = (r_sel == SEL_ODD) ? r_code_odd : r_code_even;
  // Majority vote; an exact tie reads as "code not too high".
  assign w_dec    = (32'(r_ones) > 32'(NAVG / 2));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_sel       <= SEL_EVEN;
      r_idx       <= '0;
      r_cnt       <= '0;
      r_ones      <= '0;
      r_code_even <= CODE_MID;
      r_code_odd  <= CODE_MID;
      r_calen     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_sel       <= w_sel;
      r_idx       <= w_idx;
      r_cnt       <= w_cnt;
      r_ones      <= w_ones;
      r_code_even <= w_code_even;
      r_code_odd  <= w_code_odd;
      r_calen     <= w_calen;
      r_busy      <= w_busy;
      r_done      <= w_done;
      r_err       <= w_err;
    end
  end

  always_comb begin
    w_state     = r_state;
    w_sel       = r_sel;
    w_idx       = r_idx;
    w_cnt       = r_cnt;
    w_ones      = r_ones;
    w_code_even = r_code_even;
    w_code_odd  = r_code_odd;
    w_calen     = r_calen;
    w_busy      = r_busy;
    w_done      = r_done;
    w_err       = r_err;
    w_trial     = w_active;

    unique case (r_state)
      ST_IDLE: begin
        if (cal_start && rx_en) w_state = ST_INIT;
      end
      ST_INIT: begin
        w_calen     = 1'b1;
        w_busy      = 1'b1;
        w_done      = 1'b0;
        w_err       = 1'b0;
        w_sel       = SEL_EVEN;
        w_idx       = IDX_W'(CODE_W - 1);
        w_cnt       = '0;
        w_ones      = '0;
        w_code_even = CODE_MID;
        w_state     = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (r_cnt == CNT_W'(SETTLE_CYC - 1)) begin
          w_cnt   = '0;
          w_state = ST_SAMPLE;
        end else begin
          w_cnt = r_cnt + CNT_W'(1);
        end
      end
      ST_SAMPLE: begin
        w_ones = r_ones + ONES_W'(w_sample);
        if (r_cnt == CNT_W'(NAVG - 1)) begin
          w_cnt   = '0;
          w_state = ST_DECIDE;
        end else begin
          w_cnt = r_cnt + CNT_W'(1);
        end
      end
      ST_DECIDE: begin
        if (w_dec) w_trial[r_idx] = 1'b0;
        if (r_idx != '0) w_trial[r_idx - IDX_W'(1)] = 1'b1;
        if (r_sel == SEL_ODD) w_code_odd = w_trial;
        else                  w_code_even = w_trial;
        w_ones = '0;
        if (r_idx != '0) begin
          w_idx   = r_idx - IDX_W'(1);
          w_state = ST_SETTLE;
        end else if (r_sel == SEL_EVEN) begin
          w_sel      = SEL_ODD;
          w_idx      = IDX_W'(CODE_W - 1);
          w_code_odd = CODE_MID;
          w_state    = ST_SETTLE;
        end else begin
          w_state = ST_DONE;
        end
      end
      ST_DONE: begin
        w_calen = 1'b0;
        w_busy  = 1'b0;
        w_done  = 1'b1;
        w_err   = code_sat(r_code_even) || code_sat(r_code_odd);
        if (cal_start) w_state = ST_INIT;
      end
      default: w_state = ST_IDLE;
    endcase

    // Receiver disabled mid-search: abandon and park both samplers at mid-code.
    if (!rx_en && (r_state != ST_IDLE) && (r_state != ST_DONE)) begin
      w_state     = ST_IDLE;
      w_calen     = 1'b0;
      w_busy      = 1'b0;
      w_done      = 1'b0;
      w_err       = 1'b1;
      w_cnt       = '0;
      w_ones      = '0;
      w_code_even = CODE_MID;
      w_code_odd  = CODE_MID;
    end

`ifdef RX_OFSCAL_OVRD_EN
    if (ovrd_en) begin
      w_state     = ST_IDLE;
      w_calen     = 1'b0;
      w_busy      = 1'b0;
      w_done      = r_done;
      w_err       = r_err;
      w_cnt       = '0;
      w_ones      = '0;
      w_code_even = ovrd_code_even;
      w_code_odd  = ovrd_code_odd;
    end
`endif
  end

  assign rx_calen       = r_calen;
  assign rx_ofscal_even = r_code_even;
  assign rx_ofscal_odd  = r_code_odd;
  assign cal_busy       = r_busy;
  assign cal_done       = r_done;
  assign cal_err        = r_err;

endmodule

// File: tb/tb_aibio_rx_ofscal_ctrl.sv
// Self-checking bench for aibio_rx_ofscal_ctrl with a behavioural sampler model.
module tb_aibio_rx_ofscal_ctrl;

  localparam int unsigned NAVG       = 8;
  localparam int unsigned SETTLE_CYC = 16;
  localparam int unsigned LAT        = 2 + 16 * (SETTLE_CYC + NAVG + 1);

  logic       clk;
  logic       rst_n;
  logic       cal_start;
  logic       rx_en;
  logic       rx_out_even;
  logic       rx_out_odd;
  logic       rx_calen;
  logic [7:0] rx_ofscal_even;
  logic [7:0] rx_ofscal_odd;
  logic       cal_busy;
  logic       cal_done;
  logic       cal_err;
`ifdef RX_OFSCAL_OVRD_EN
  logic       ovrd_en;
  logic [7:0] ovrd_code_even;
  logic [7:0] ovrd_code_odd;
`endif

  int errors;
  int checks;

  // Sampler model: comparator against a hidden target, or a periodic bit pattern.
  int         mode;
  logic [7:0] tgt_even, tgt_odd;
  logic [7:0] pat_even, pat_odd;
  logic [2:0] r_pcnt;

  aibio_rx_ofscal_ctrl #(
    .SETTLE_CYC  (SETTLE_CYC),
    .NAVG        (NAVG),
    .SYNC_STAGES (2)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cal_start      (cal_start),
    .rx_en          (rx_en),
    .rx_out_even    (rx_out_even),
    .rx_out_odd     (rx_out_odd),
`ifdef RX_OFSCAL_OVRD_EN
    .ovrd_en        (ovrd_en),
    .ovrd_code_even (ovrd_code_even),
    .ovrd_code_odd  (ovrd_code_odd),
`endif
    .rx_calen       (rx_calen),
    .rx_ofscal_even (rx_ofscal_even),
    .rx_ofscal_odd  (rx_ofscal_odd),
    .cal_busy       (cal_busy),
    .cal_done       (cal_done),
    .cal_err        (cal_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) r_pcnt <= r_pcnt + 3'd1;

  always_comb begin
    rx_out_even = 1'b0;
    rx_out_odd  = 1'b0;
    if (mode == 0) begin
      rx_out_even = (rx_ofscal_even > tgt_even);
      rx_out_odd  = (rx_ofscal_odd > tgt_odd);
    end else begin
      rx_out_even = pat_even[r_pcnt];
      rx_out_odd  = pat_odd[r_pcnt];
    end
  end

  // Expected final code: a binary search over a monotonic comparator lands on
  // its target; a constant majority answer drives the code to one rail.
  function automatic logic [7:0] ref_code(input int m, input logic [7:0] tgt,
                                          input logic [7:0] pat);
    if (m == 0) return tgt;
    return ($countones(pat) * 2 > NAVG) ? 8'h00 : 8'hFF;
  endfunction

  function automatic logic ref_err(input logic [7:0] a, input logic [7:0] b);
    return (a == 8'h00) || (a == 8'hFF) || (b == 8'h00) || (b == 8'hFF);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string name);
    checks++;
    if ({rx_calen, cal_busy, cal_done, cal_err} !== 4'b0000 ||
        rx_ofscal_even !== 8'h80 || rx_ofscal_odd !== 8'h80) begin
      errors++;
      $display("FAIL %s: calen/busy/done/err=%b%b%b%b codes=%h/%h expected 0000 80/80",
               name, rx_calen, cal_busy, cal_done, cal_err, rx_ofscal_even, rx_ofscal_odd);
    end
  endtask

  // Full calibration with latency check; poke_at>0 pulses cal_start mid-run.
  task automatic run_cal(input string name, input int poke_at);
    logic [7:0] exp_e, exp_o;
    int bad;
    exp_e = ref_code(mode, tgt_even, pat_even);
    exp_o = ref_code(mode, tgt_odd, pat_odd);
    bad = 0;
    cal_start = 1'b1;
    tick();
    cal_start = 1'b0;
    for (int i = 1; i < int'(LAT); i++) begin
      if (i == poke_at) cal_start = 1'b1;
      tick();
      cal_start = 1'b0;
      if (rx_calen !== 1'b1 || cal_busy !== 1'b1 || cal_done !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s busy window: %0d cycles wrong, last calen/busy/done=%b%b%b expected 110",
               name, bad, rx_calen, cal_busy, cal_done);
    end
    tick();
    checks++;
    if (cal_done !== 1'b1 || cal_busy !== 1'b0 || rx_calen !== 1'b0) begin
      errors++;
      $display("FAIL %s done at %0d: done/busy/calen=%b%b%b expected 100",
               name, LAT, cal_done, cal_busy, rx_calen);
    end
    checks++;
    if (rx_ofscal_even !== exp_e || rx_ofscal_odd !== exp_o) begin
      errors++;
      $display("FAIL %s codes: got %h/%h expected %h/%h",
               name, rx_ofscal_even, rx_ofscal_odd, exp_e, exp_o);
    end
    checks++;
    if (cal_err !== ref_err(exp_e, exp_o)) begin
      errors++;
      $display("FAIL %s err: got %b expected %b", name, cal_err, ref_err(exp_e, exp_o));
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    check_reset_vals("reset");
  endtask

  task automatic test_nominal();
    mode = 0;
    tgt_even = 8'h5A;
    tgt_odd  = 8'hC3;
    run_cal("nominal", 0);
  endtask

  task automatic test_random();
    mode = 0;
    for (int k = 0; k < 4; k++) begin
      tgt_even = 8'($urandom_range(255));
      tgt_odd  = 8'($urandom_range(255));
      repeat ($urandom_range(3)) tick();
      run_cal("random", 0);
    end
  endtask

  task automatic test_saturation();
    mode = 0;
    tgt_even = 8'hFF;
    tgt_odd  = 8'($urandom_range(1, 254));
    run_cal("saturation", 0);
  endtask

  task automatic test_majority();
    mode = 1;
    pat_even = 8'b0000_1111;
    pat_odd  = 8'b0101_0101;
    run_cal("tie4", 0);
    pat_even = 8'b0001_1111;
    pat_odd  = 8'b1101_0101;
    run_cal("maj5", 0);
    pat_even = 8'($urandom);
    pat_odd  = 8'($urandom);
    run_cal("pattern_rand", 0);
    mode = 0;
  endtask

  task automatic test_abort();
    mode = 0;
    tgt_even = 8'h33;
    tgt_odd  = 8'h44;
    cal_start = 1'b1;
    tick();
    cal_start = 1'b0;
    repeat (149) tick();
    rx_en = 1'b0;
    tick();
    checks++;
    if (cal_busy !== 1'b0 || rx_calen !== 1'b0 || cal_err !== 1'b1 || cal_done !== 1'b0 ||
        rx_ofscal_even !== 8'h80 || rx_ofscal_odd !== 8'h80) begin
      errors++;
      $display("FAIL abort: busy/calen/err/done=%b%b%b%b codes=%h/%h expected 0010 80/80",
               cal_busy, rx_calen, cal_err, cal_done, rx_ofscal_even, rx_ofscal_odd);
    end
    cal_start = 1'b1;
    tick();
    cal_start = 1'b0;
    tick();
    checks++;
    if (cal_busy !== 1'b0 || rx_calen !== 1'b0) begin
      errors++;
      $display("FAIL start_disabled: busy/calen=%b%b expected 00", cal_busy, rx_calen);
    end
    rx_en = 1'b1;
    run_cal("after_abort", 0);
  endtask

  task automatic test_back_to_back();
    mode = 0;
    tgt_even = 8'h01;
    tgt_odd  = 8'h7E;
    run_cal("ignore_start", 100);
    tgt_even = 8'hA5;
    tgt_odd  = 8'h3C;
    run_cal("restart_from_done", 0);
  endtask

  task automatic test_reset_mid();
    mode = 0;
    tgt_even = 8'h90;
    tgt_odd  = 8'h20;
    cal_start = 1'b1;
    tick();
    cal_start = 1'b0;
    repeat (199) tick();
    rst_n = 1'b0;
    tick();
    check_reset_vals("reset_mid");
    rst_n = 1'b1;
    tick();
    check_reset_vals("reset_release_idle");
  endtask

`ifdef RX_OFSCAL_OVRD_EN
  task automatic test_override();
    mode = 0;
    tgt_even = 8'h60;
    tgt_odd  = 8'h61;
    cal_start = 1'b1;
    tick();
    cal_start = 1'b0;
    repeat (99) tick();
    ovrd_code_even = 8'h11;
    ovrd_code_odd  = 8'h22;
    ovrd_en = 1'b1;
    tick();
    checks++;
    if (rx_ofscal_even !== 8'h11 || rx_ofscal_odd !== 8'h22 || rx_calen !== 1'b0 ||
        cal_busy !== 1'b0 || cal_err !== 1'b0) begin
      errors++;
      $display("FAIL override: codes=%h/%h calen/busy/err=%b%b%b expected 11/22 000",
               rx_ofscal_even, rx_ofscal_odd, rx_calen, cal_busy, cal_err);
    end
    cal_start = 1'b1;
    tick();
    cal_start = 1'b0;
    tick();
    checks++;
    if (cal_busy !== 1'b0 || rx_ofscal_even !== 8'h11) begin
      errors++;
      $display("FAIL override_hold: busy=%b code=%h expected 0 11", cal_busy, rx_ofscal_even);
    end
    ovrd_en = 1'b0;
    tick();
    run_cal("after_override", 0);
  endtask
`endif

  initial begin
    errors    = 0;
    checks    = 0;
    r_pcnt    = 3'd0;
    mode      = 0;
    tgt_even  = 8'h00;
    tgt_odd   = 8'h00;
    pat_even  = 8'h00;
    pat_odd   = 8'h00;
    rst_n     = 1'b0;
    cal_start = 1'b0;
    rx_en     = 1'b1;
`ifdef RX_OFSCAL_OVRD_EN
    ovrd_en        = 1'b0;
    ovrd_code_even = 8'h00;
    ovrd_code_odd  = 8'h00;
`endif
    test_reset();
    test_nominal();
    test_random();
    test_saturation();
    test_majority();
    test_abort();
    test_back_to_back();
    test_reset_mid();
`ifdef RX_OFSCAL_OVRD_EN
    test_override();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
